// File: rtl/mem_arb_pkg.sv
// Shared types and node-memory map for the memory arbiter slice.
// The map constants give engines a single source for field base addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } ArbState;

    localparam logic [15:0] KNOWN_SINKS    = 16'h0008;
    localparam logic [15:0] NEIGHBOR_ID    = 16'h0048;
    localparam logic [15:0] CLUSTER_ID     = 16'h00C8;
    localparam logic [15:0] QVALUE         = 16'h01C8;
    localparam logic [15:0] SINK_IDS       = 16'h0248;
    localparam logic [15:0] HCM            = 16'h0648;
    localparam logic [15:0] KNOWN_SINK_CNT = 16'h0688;
    localparam logic [15:0] NEIGHBOR_CNT   = 16'h068A;
    localparam logic [15:0] SINK_ID_CNT    = 16'h068E;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after rrPtr_i,
// searching circularly, so the previous winner has lowest priority.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [IDX_W-1:0] rrPtr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(rrPtr_i) + k) % N_REQ);
            if (!valid_o && eligible_i[cand]) begin
                winner_o[cand] = 1'b1;
                valid_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and 3-cycle access sequencer in front of the single-port
// node memory, with an optional lock for atomic read-modify-write sequences.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = 2048
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        ack,
    output logic                    err,
    output logic [DATA_W-1:0]       rdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_wr_en,
    output logic [DATA_W-1:0]       mem_data_in,
    input  logic [DATA_W-1:0]       mem_data_out
);

    localparam int IDX_W = $clog2(N_REQ);

    ArbState           state_q, state_d;
    logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              lockValid_q, lockValid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              lockHeld;
    logic [N_REQ-1:0]  ownerMask;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  winner;
    logic              winValid;
    logic [IDX_W-1:0]  winIdx;
    logic              addrLegal;

    // A locked owner that has dropped lock no longer restricts arbitration,
    // so release and a fresh round-robin pick happen in the same IDLE cycle.
    always_comb begin
        lockHeld  = lockValid_q && lock[owner_q];
        ownerMask = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
        eligible  = lockHeld ? (req & ownerMask) : req;
        addrLegal = !addr_q[0] && (addr_q <= ADDR_W'(MEM_BYTES - 2));
        winIdx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                winIdx = IDX_W'(i);
            end
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) uPick (
        .eligible_i (eligible),
        .rrPtr_i    (rrPtr_q),
        .winner_o   (winner),
        .valid_o    (winValid)
    );

    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        lockValid_d = lockValid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                lockValid_d = lockHeld;
                if (winValid) begin
                    addr_d  = addr[int'(winIdx)*ADDR_W +: ADDR_W];
                    wdata_d = wdata[int'(winIdx)*DATA_W +: DATA_W];
                    we_d    = we[winIdx];
                    gnt_d   = winner;
                    owner_d = winIdx;
                    rrPtr_d = winIdx;
                    state_d = ACCESS;
                end else if (!lockHeld) begin
                    gnt_d = '0;
                end
            end
            ACCESS: begin
                rdata_d = (!we_q && addrLegal) ? mem_data_out : '0;
                err_d   = !addrLegal;
                state_d = DONE;
            end
            DONE: begin
                if (lock[owner_q]) begin
                    lockValid_d = 1'b1;
                end else begin
                    lockValid_d = 1'b0;
                    gnt_d       = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rrPtr_q     <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            gnt_q       <= '0;
            lockValid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            lockValid_q <= lockValid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Memory bus is left ungated by reset: mem has no reset, so a write in
    // flight still lands; only the ack is withheld.
    assign ack         = (state_q == DONE && !reset) ? gnt_q : '0;
    assign gnt         = gnt_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign mem_address = (state_q == ACCESS) ? addr_q : '0;
    assign mem_data_in = (state_q == ACCESS) ? wdata_q : '0;
    assign mem_wr_en   = (state_q == ACCESS) && we_q && addrLegal;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural node memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 2048;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [N-1:0]  we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]  ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic [N-1:0]  gnt;
    logic [AW-1:0] mem_address;
    logic          mem_wr_en;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    logic [7:0] memB [0:MB-1];
    logic       loaded = 1'b0;
    int         wrEnCount = 0;
    logic       watchLock = 1'b0;
    logic       sawGnt0 = 1'b0;
    int         passCount = 0;
    int         checkCount = 0;

    always #5 clock = ~clock;

    mem_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_BYTES (MB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .lock         (lock),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .gnt          (gnt),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Big-endian byte memory, preloaded on the first edge while reset is held.
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < MB; i++) memB[i] <= 8'h00;
            memB[11'h688] <= 8'h00; memB[11'h689] <= 8'h05;
            memB[11'h68A] <= 8'h00; memB[11'h68B] <= 8'h02;
            memB[11'h048] <= 8'h00; memB[11'h049] <= 8'h01;
            memB[11'h68E] <= 8'h00; memB[11'h68F] <= 8'h03;
            memB[11'h648] <= 8'h20; memB[11'h649] <= 8'h00;
            loaded <= 1'b1;
        end else if (mem_wr_en) begin
            memB[mem_address[10:0]]         <= mem_data_in[15:8];
            memB[mem_address[10:0] + 11'd1] <= mem_data_in[7:0];
            wrEnCount <= wrEnCount + 1;
        end
    end

    assign mem_data_out = (mem_address < 16'd2047) ?
        {memB[mem_address[10:0]], memB[mem_address[10:0] + 11'd1]} : 16'h0000;

    always @(negedge clock) begin
        if (watchLock && gnt[0]) sawGnt0 <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int idx, input logic reqBit, input logic lockBit,
                                 input logic weBit, input logic [15:0] a, input logic [15:0] d);
        req[idx]             = reqBit;
        lock[idx]            = lockBit;
        we[idx]              = weBit;
        addr[idx*AW +: AW]   = a;
        wdata[idx*DW +: DW]  = d;
    endtask

    task automatic waitAck(input int idx, input string tag, output logic [15:0] rd,
                           output logic er, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        rd     = '0;
        er     = 1'b0;
        for (int c = 1; c <= 12 && !found; c++) begin
            @(negedge clock);
            if (ack[idx]) begin
                found  = 1'b1;
                cycles = c;
                rd     = rdata;
                er     = err;
            end
        end
        if (!found) checkOutput({tag, " ack timeout"}, 32'd0, 32'd1);
    endtask

    task automatic doAccess(input int idx, input logic weBit, input logic [15:0] a,
                            input logic [15:0] d, input string tag,
                            output logic [15:0] rd, output logic er);
        int cyc;
        @(posedge clock); #1;
        applyStimulus(idx, 1'b1, 1'b0, weBit, a, d);
        waitAck(idx, tag, rd, er, cyc);
        applyStimulus(idx, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          cyc;
        int          wrBefore;
        int          order [4];
        int          ackCyc [4];
        int          nAck;

        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset ack", ack, 0);
        checkOutput("reset gnt", gnt, 0);
        checkOutput("reset rdata/err", {rdata, err}, 0);
        checkOutput("reset mem addr/wr_en", {mem_address, mem_wr_en}, 0);
        checkOutput("reset mem data_in", mem_data_in, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single read with cycle-accurate latency
        @(posedge clock); #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, KNOWN_SINK_CNT, 16'h0);
        @(negedge clock);
        checkOutput("read idle gnt", gnt, 4'b0000);
        @(negedge clock);
        checkOutput("read access gnt", gnt, 4'b0001);
        checkOutput("read access mem_address", mem_address, 16'h0688);
        checkOutput("read access wr_en", mem_wr_en, 0);
        @(negedge clock);
        checkOutput("read ack", ack, 4'b0001);
        checkOutput("read rdata", rdata, 16'h0005);
        checkOutput("read err", err, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock);
        checkOutput("ack one-cycle pulse", ack, 0);
        checkOutput("gnt cleared after unlocked ack", gnt, 0);

        // Write then read back
        doAccess(1, 1'b1, NEIGHBOR_CNT, 16'h0007, "wr 68A", rd, er);
        checkOutput("write err", er, 0);
        doAccess(1, 1'b0, NEIGHBOR_CNT, 16'h0000, "rd 68A", rd, er);
        checkOutput("write-read rdata", rd, 16'h0007);

        // Contention after reset: expect grants 0,1,2,3 with acks 3 cycles apart
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b1, 1'b0, 1'b0, NEIGHBOR_ID, 16'h0);
            order[i]  = -1;
            ackCyc[i] = -1;
        end
        nAck = 0;
        for (int c = 1; c <= 20 && nAck < 4; c++) begin
            @(negedge clock);
            for (int j = 0; j < 4; j++) begin
                if (ack[j]) begin
                    if (nAck < 4) begin
                        order[nAck]  = j;
                        ackCyc[nAck] = c;
                    end
                    nAck++;
                    checkOutput("contention rdata", rdata, 16'h0001);
                    applyStimulus(j, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        checkOutput("contention ack count", nAck, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("contention grant order", order[k], k);
            checkOutput("contention ack cycle", ackCyc[k], 3 + 3 * k);
        end

        // Locked read-modify-write by requester 2 while requester 0 waits
        @(posedge clock); #1;
        applyStimulus(2, 1'b1, 1'b1, 1'b0, SINK_ID_CNT, 16'h0);
        watchLock = 1'b1;
        @(posedge clock); #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, KNOWN_SINK_CNT, 16'h0);
        waitAck(2, "lock rd", rd, er, cyc);
        checkOutput("lock read rdata", rd, 16'h0003);
        applyStimulus(2, 1'b1, 1'b1, 1'b1, SINK_ID_CNT, 16'h0004);
        waitAck(2, "lock wr", rd, er, cyc);
        checkOutput("lock write err", er, 0);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
        for (int h = 0; h < 3; h++) begin
            @(negedge clock);
            checkOutput("lock hold gnt", gnt, 4'b0100);
            checkOutput("lock hold ack", ack, 0);
        end
        watchLock = 1'b0;
        checkOutput("req0 blocked while locked", sawGnt0, 0);
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        waitAck(0, "req0 after unlock", rd, er, cyc);
        checkOutput("req0 after unlock latency", cyc, 2);
        checkOutput("req0 after unlock rdata", rd, 16'h0005);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        doAccess(3, 1'b0, SINK_ID_CNT, 16'h0, "rd 68E", rd, er);
        checkOutput("locked increment result", rd, 16'h0004);

        // Illegal accesses
        wrBefore = wrEnCount;
        doAccess(1, 1'b1, 16'h0649, 16'hBEEF, "wr 649", rd, er);
        checkOutput("odd write err", er, 1);
        checkOutput("odd write wr_en pulses", wrEnCount - wrBefore, 0);
        doAccess(2, 1'b0, 16'h07FF, 16'h0, "rd 7FF", rd, er);
        checkOutput("out-of-range read err", er, 1);
        checkOutput("out-of-range read rdata", rd, 16'h0000);
        doAccess(1, 1'b0, HCM, 16'h0, "rd 648", rd, er);
        checkOutput("HCM untouched", rd, 16'h2000);
        checkOutput("HCM read err", er, 0);

        // Reset during the ACCESS cycle of a write
        @(posedge clock); #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, KNOWN_SINK_CNT, 16'h0009);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset-in-access wr_en", mem_wr_en, 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset ack", ack, 0);
        checkOutput("post-reset gnt", gnt, 0);
        checkOutput("post-reset rdata/err", {rdata, err}, 0);
        checkOutput("post-reset mem bus", {mem_address, mem_wr_en, mem_data_in}, 0);
        @(negedge clock);
        checkOutput("no late ack", ack, 0);
        @(posedge clock); #1;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, KNOWN_SINK_CNT, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, KNOWN_SINK_CNT, 16'h0);
        waitAck(0, "post-reset req0", rd, er, cyc);
        checkOutput("post-reset req0 wins first", cyc, 3);
        checkOutput("write landed through reset", rd, 16'h0009);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        waitAck(1, "post-reset req1", rd, er, cyc);
        checkOutput("post-reset req1 rdata", rd, 16'h0009);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
